// File: rtl/iq_demod.sv
// iq_demod: coherent quadrature receiver.
// Mixes a signed sample stream against an internal sin/cos local oscillator
// (phase accumulator + sine LUT), then integrates-and-dumps over a
// programmable window, emitting one I/Q pair per window.
// Optional build macro IQ_DEMOD_SAT_EN: saturating accumulation with an
// ovf flag; when undefined the accumulators wrap and ovf is tied low.
module iq_demod #(
  parameter int PW = 32,
  parameter int DW = 10,
  parameter int LW = 10,
  parameter int AW = 13,
  parameter int NW = 16,
  parameter int OW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] in,
  input  logic        [PW-1:0] freq,
  input  logic        [PW-1:0] phase,
  input  logic        [NW-1:0] len,
  output logic signed [OW-1:0] i_out,
  output logic signed [OW-1:0] q_out,
  output logic                 out_valid,
  output logic                 ovf
);

  localparam int unsigned LUT_N = 2 ** AW;
  localparam int unsigned QTR   = LUT_N / 4;
  localparam int          PEAK  = 2 ** (LW - 1) - 1;
  localparam logic [PW-1:0] QTR_PH = PW'(1) << (PW - 2);

  // Quarter-wave symmetry keeps the exact +/-peak and zero points exact.
  function automatic int sine_entry(input int unsigned idx);
    int unsigned q;
    int unsigned r;
    int unsigned rr;
    real x;
    real term;
    real s;
    int mag;
    q  = idx / QTR;
    r  = idx % QTR;
    rr = (q % 2 == 1) ? (QTR - r) : r;
    if (rr == QTR) begin
      mag = PEAK;
    end else begin
      x    = 2.0 * 3.141592653589793 * real'(rr) / real'(LUT_N);
      term = x;
      s    = x;
      for (int unsigned n = 1; n <= 12; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      mag = $rtoi(s * real'(PEAK));
    end
    return (q >= 2) ? -mag : mag;
  endfunction

  logic signed [LW-1:0] w_lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam int V = sine_entry(g);
    assign w_lut[g] = LW'(V);
  end

  // Front end: phase accumulator and window counter
  logic [PW-1:0] r_acc;
  logic [NW-1:0] r_cnt;
  logic [NW-1:0] r_len;
  logic [NW-1:0] w_len_eff;
  logic [NW-1:0] w_len_cur;
  logic [NW:0]   w_cnt_nx;
  logic          w_last;

  assign w_len_eff = (len == '0) ? NW'(1) : len;
  assign w_len_cur = (r_cnt == '0) ? w_len_eff : r_len;
  assign w_cnt_nx  = {1'b0, r_cnt} + {{NW{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_nx == {1'b0, w_len_cur});

  // Advance phase and window count on accepted samples only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (en) begin
      r_acc <= r_acc + freq;
      if (r_cnt == '0) r_len <= w_len_eff;
      r_cnt <= w_last ? '0 : w_cnt_nx[NW-1:0];
    end
  end

  // S1: sample, LUT addresses of both phase sums, window markers
  logic                 r_s1_v, r_s1_first, r_s1_last;
  logic signed [DW-1:0] r_s1_in;
  logic        [AW-1:0] r_s1_sa, r_s1_ca;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_in    <= '0;
      r_s1_sa    <= '0;
      r_s1_ca    <= '0;
    end else begin
      r_s1_v     <= en;
      r_s1_first <= (r_cnt == '0);
      r_s1_last  <= w_last;
      r_s1_in    <= in;
      r_s1_sa    <= AW'((r_acc + phase) >> (PW - AW));
      r_s1_ca    <= AW'((r_acc + phase + QTR_PH) >> (PW - AW));
    end
  end

  // S2: LUT reads
  logic                 r_s2_v, r_s2_first, r_s2_last;
  logic signed [DW-1:0] r_s2_in;
  logic signed [LW-1:0] r_s2_sin, r_s2_cos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v     <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_in    <= '0;
      r_s2_sin   <= '0;
      r_s2_cos   <= '0;
    end else begin
      r_s2_v     <= r_s1_v;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_in    <= r_s1_in;
      r_s2_sin   <= w_lut[r_s1_sa];
      r_s2_cos   <= w_lut[r_s1_ca];
    end
  end

  // S3: mixer products
  logic                    r_s3_v, r_s3_first, r_s3_last;
  logic signed [DW+LW-1:0] r_s3_pi, r_s3_pq;
  logic signed [DW+LW-1:0] w_in_x, w_cos_x, w_sin_x;

  assign w_in_x  = $signed({{LW{r_s2_in[DW-1]}}, r_s2_in});
  assign w_cos_x = $signed({{DW{r_s2_cos[LW-1]}}, r_s2_cos});
  assign w_sin_x = $signed({{DW{r_s2_sin[LW-1]}}, r_s2_sin});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_v     <= 1'b0;
      r_s3_first <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_pi    <= '0;
      r_s3_pq    <= '0;
    end else begin
      r_s3_v     <= r_s2_v;
      r_s3_first <= r_s2_first;
      r_s3_last  <= r_s2_last;
      r_s3_pi    <= w_in_x * w_cos_x;
      r_s3_pq    <= w_in_x * w_sin_x;
    end
  end

  // S4: integrate-and-dump
  logic signed [OW-1:0] r_acc_i, r_acc_q;
  logic signed [OW-1:0] w_pi_ext, w_pq_ext, w_base_i, w_base_q, w_new_i, w_new_q;

  assign w_pi_ext = OW'(r_s3_pi);
  assign w_pq_ext = OW'(r_s3_pq);
  assign w_base_i = r_s3_first ? '0 : r_acc_i;
  assign w_base_q = r_s3_first ? '0 : r_acc_q;

`ifdef IQ_DEMOD_SAT_EN
  localparam logic signed [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};
  logic signed [OW:0] w_sum_i, w_sum_q;
  logic               w_sat_i, w_sat_q, w_win_sat, r_sat;

  // Saturating add; window saturation is sticky until the dump
  always_comb begin
    w_sum_i   = (OW+1)'(w_base_i) + (OW+1)'(w_pi_ext);
    w_sum_q   = (OW+1)'(w_base_q) + (OW+1)'(w_pq_ext);
    w_sat_i   = w_sum_i[OW] ^ w_sum_i[OW-1];
    w_sat_q   = w_sum_q[OW] ^ w_sum_q[OW-1];
    w_new_i   = w_sat_i ? (w_sum_i[OW] ? MINV : MAXV) : w_sum_i[OW-1:0];
    w_new_q   = w_sat_q ? (w_sum_q[OW] ? MINV : MAXV) : w_sum_q[OW-1:0];
    w_win_sat = (!r_s3_first && r_sat) || w_sat_i || w_sat_q;
  end
`else
  // Wrapping add
  always_comb begin
    w_new_i = w_base_i + w_pi_ext;
    w_new_q = w_base_q + w_pq_ext;
  end
  assign ovf = 1'b0;
`endif

  // Accumulate, or present the window total and restart on the last sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
`ifdef IQ_DEMOD_SAT_EN
      r_sat     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (r_s3_v) begin
        if (r_s3_last) begin
          i_out     <= w_new_i;
          q_out     <= w_new_q;
          out_valid <= 1'b1;
          r_acc_i   <= '0;
          r_acc_q   <= '0;
`ifdef IQ_DEMOD_SAT_EN
          ovf       <= w_win_sat;
          r_sat     <= 1'b0;
`endif
        end else begin
          r_acc_i <= w_new_i;
          r_acc_q <= w_new_q;
`ifdef IQ_DEMOD_SAT_EN
          r_sat   <= w_win_sat;
`endif
        end
      end
    end
  end

endmodule
